// File: rtl/hack_mem_pkg.sv
// rtl/hack_mem_pkg.sv - shared widths and loader state encoding for the data RAM path
package hack_mem_pkg;

   localparam int BYTE_WIDTH     = 8;
   localparam int RAM_ADDR_WIDTH = 4;
   localparam int RAM_DATA_WIDTH = 16;

   typedef enum logic [2:0] {
      LD_IDLE,
      LD_HIGH,
      LD_LOW,
      LD_WRITE,
      LD_DONE
   } loader_state_t;

endpackage

// File: rtl/ram_loader_if.sv
// rtl/ram_loader_if.sv - byte stream handshake feeding the RAM loader
interface ram_loader_if;
   import hack_mem_pkg::*;

   logic [BYTE_WIDTH-1:0] byte_in;
   logic                  byte_valid;
   logic                  byte_ready;

   modport master (output byte_in, output byte_valid, input byte_ready);
   modport slave  (input byte_in, input byte_valid, output byte_ready);

endinterface

// File: rtl/ram_loader_word_assembler.sv
// rtl/ram_loader_word_assembler.sv - holds the high/low bytes of the word being loaded
module word_assembler
   import hack_mem_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_hi,
   input  logic                    load_lo,
   input  logic [BYTE_WIDTH-1:0]   byte_in,
   output logic [2*BYTE_WIDTH-1:0] word
);

   logic [BYTE_WIDTH-1:0] hi;
   logic [BYTE_WIDTH-1:0] lo;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi <= '0;
         lo <= '0;
      end else begin
         if (load_hi) hi <= byte_in;
         if (load_lo) lo <= byte_in;
      end
   end

   // Big-endian: the first byte of each pair is the upper half of the word.
   assign word = {hi, lo};

endmodule

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - preloads the data RAM from a byte stream, else passes the CPU port through
module ram_loader
   import hack_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
   parameter int DATA_WIDTH = RAM_DATA_WIDTH
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   ram_loader_if.slave           stream,
   input  logic [ADDR_WIDTH-1:0] cpu_address,
   input  logic [DATA_WIDTH-1:0] cpu_in,
   input  logic                  cpu_load,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0] ram_in,
   output logic                  ram_load,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   count
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   loader_state_t         state, state_next;
   logic [ADDR_WIDTH-1:0] ptr;
   logic                  load_hi, load_lo;
   logic [DATA_WIDTH-1:0] word;

   word_assembler u_word_assembler (
      .clk     (clk),
      .rst     (rst),
      .load_hi (load_hi),
      .load_lo (load_lo),
      .byte_in (stream.byte_in),
      .word    (word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= LD_IDLE;
         ptr   <= '0;
         count <= '0;
      end else begin
         state <= state_next;
         if (state == LD_IDLE && start) begin
            ptr   <= '0;
            count <= '0;
         end else if (state == LD_WRITE) begin
            count <= count + 1'b1;
            if (ptr != LAST_ADDR) ptr <= ptr + 1'b1;
         end
      end
   end

   // The CPU port owns the RAM in IDLE and DONE; cpu_load is simply dropped otherwise.
   always_comb begin
      state_next        = state;
      load_hi           = 1'b0;
      load_lo           = 1'b0;
      stream.byte_ready = 1'b0;
      busy              = 1'b0;
      done              = 1'b0;
      ram_address       = cpu_address;
      ram_in            = cpu_in;
      ram_load          = cpu_load;
      case (state)
         LD_IDLE: begin
            if (start) state_next = LD_HIGH;
         end
         LD_HIGH: begin
            stream.byte_ready = 1'b1;
            busy              = 1'b1;
            ram_address       = ptr;
            ram_in            = word;
            ram_load          = 1'b0;
            if (stream.byte_valid) begin
               load_hi    = 1'b1;
               state_next = LD_LOW;
            end
         end
         LD_LOW: begin
            stream.byte_ready = 1'b1;
            busy              = 1'b1;
            ram_address       = ptr;
            ram_in            = word;
            ram_load          = 1'b0;
            if (stream.byte_valid) begin
               load_lo    = 1'b1;
               state_next = LD_WRITE;
            end
         end
         LD_WRITE: begin
            busy        = 1'b1;
            ram_address = ptr;
            ram_in      = word;
            ram_load    = 1'b1;
            state_next  = (ptr == LAST_ADDR) ? LD_DONE : LD_HIGH;
         end
         LD_DONE: begin
            done       = 1'b1;
            state_next = LD_IDLE;
         end
         default: state_next = LD_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - randomized scoreboard bench for ram_loader
module tb_ram_loader;
   import hack_mem_pkg::*;

   localparam int AW = 4;
   localparam int DW = 16;
   localparam int NW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] cpu_address;
   logic [DW-1:0] cpu_in;
   logic          cpu_load;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_in;
   logic          ram_load;
   logic          busy;
   logic          done;
   logic [AW:0]   count;

   ram_loader_if stream ();

   ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stream      (stream),
      .cpu_address (cpu_address),
      .cpu_in      (cpu_in),
      .cpu_load    (cpu_load),
      .ram_address (ram_address),
      .ram_in      (ram_in),
      .ram_load    (ram_load),
      .busy        (busy),
      .done        (done),
      .count       (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   int          vectors = 0;
   int          miscompares = 0;
   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [DW-1:0] mem [NW];
   logic [7:0]  bytes_a [2*NW];
   int          writes_seen = 0;
   int          dones_seen = 0;
   int          busy_cycles = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Behavioural RAM: captures on the edge ending any cycle with ram_load high.
   always @(posedge clk) begin
      if (ram_load) mem[ram_address] <= ram_in;
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (busy) begin
            busy_cycles++;
            check("ram_load_only_when_not_ready", {31'd0, ram_load}, {31'd0, !stream.byte_ready});
            if (ram_load) begin
               writes_seen++;
               if (exp_q.size() == 0) begin
                  check("unexpected_write", 32'd1, 32'd0);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("write_addr", {28'd0, ram_address}, {28'd0, mon_e.addr});
                  check("write_data", {16'd0, ram_in}, {16'd0, mon_e.data});
               end
            end
         end else begin
            check("passthrough", {11'd0, ram_address, ram_in, ram_load},
                  {11'd0, cpu_address, cpu_in, cpu_load});
            check("ready_when_idle", {31'd0, stream.byte_ready}, 32'd0);
            if (done) dones_seen++;
         end
      end
   end

   task automatic feed(input int n, input int mode, input bit cpu_poke, input bit poke_start);
      int  idx = 0;
      int  budget = 0;
      bit  v;
      while (idx < n && budget < 1000) begin
         @(negedge clk);
         budget++;
         case (mode)
            0:       v = 1'b1;
            1:       v = budget[0];
            default: v = 1'($urandom % 2);
         endcase
         stream.byte_valid = v;
         stream.byte_in    = bytes_a[idx];
         cpu_load          = cpu_poke;
         start             = poke_start && ($urandom % 4 == 0);
         if (v && stream.byte_ready) idx++;
      end
      if (idx < n) check("feed_timeout", idx, n);
      @(negedge clk);
      stream.byte_valid = 1'b0;
      cpu_load          = 1'b0;
      start             = 1'b0;
   endtask

   task automatic prepare(input bit pattern);
      wr_t w;
      for (int k = 0; k < 2*NW; k++) bytes_a[k] = pattern ? 8'(k) : 8'($urandom);
      for (int k = 0; k < NW; k++) begin
         w.addr = AW'(k);
         w.data = {bytes_a[2*k], bytes_a[2*k+1]};
         exp_q.push_back(w);
      end
   endtask

   task automatic run_load(input int mode, input bit pattern, input bit cpu_poke, input bit poke_start);
      int w0, d0, b0;
      prepare(pattern);
      w0 = writes_seen;
      d0 = dones_seen;
      b0 = busy_cycles;
      @(negedge clk);
      start = 1'b1;
      feed(2*NW, mode, cpu_poke, poke_start);
      repeat (3) @(negedge clk);
      check("write_pulses", writes_seen - w0, NW);
      check("done_pulses", dones_seen - d0, 1);
      check("count_final", {27'd0, count}, NW);
      check("queue_drained", exp_q.size(), 0);
      if (mode == 0) check("busy_cycles", busy_cycles - b0, 3*NW);
      for (int k = 0; k < NW; k++)
         check("ram_word", {16'd0, mem[k]}, {16'd0, bytes_a[2*k], bytes_a[2*k+1]});
   endtask

   initial begin
      int            w0;
      logic [DW-1:0] keep2;
      rst               = 1'b1;
      start             = 1'b0;
      stream.byte_valid = 1'b0;
      stream.byte_in    = '0;
      cpu_address       = 4'd3;
      cpu_in            = 16'hBEEF;
      cpu_load          = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_ram_address", {28'd0, ram_address}, 32'd3);
      check("reset_ram_in", {16'd0, ram_in}, 32'hBEEF);
      check("reset_ram_load", {31'd0, ram_load}, 32'd1);
      check("reset_byte_ready", {31'd0, stream.byte_ready}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_count", {27'd0, count}, 32'd0);
      cpu_load = 1'b0;

      run_load(0, 1'b1, 1'b0, 1'b0);
      run_load(1, 1'b0, 1'b0, 1'b1);
      cpu_address = 4'd5;
      cpu_in      = 16'hDEAD;
      run_load(2, 1'b0, 1'b1, 1'b0);

      prepare(1'b0);
      w0 = writes_seen;
      keep2 = mem[2];
      @(negedge clk);
      start = 1'b1;
      feed(5, 0, 1'b0, 1'b0);
      check("partial_count", {27'd0, count}, 32'd2);
      rst = 1'b1;
      #1;
      check("midreset_busy", {31'd0, busy}, 32'd0);
      check("midreset_ready", {31'd0, stream.byte_ready}, 32'd0);
      check("midreset_count", {27'd0, count}, 32'd0);
      exp_q.delete();
      check("partial_writes", writes_seen - w0, 2);
      @(negedge clk);
      rst = 1'b0;
      check("partial_word0", {16'd0, mem[0]}, {16'd0, bytes_a[0], bytes_a[1]});
      check("partial_word1", {16'd0, mem[1]}, {16'd0, bytes_a[2], bytes_a[3]});
      check("partial_word2_kept", {16'd0, mem[2]}, {16'd0, keep2});

      run_load(2, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
